// File: rtl/vram_arbiter_if.sv
// CPU request/ack bus and single-port video RAM bus shared by the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the CPU/RAM side.
interface vram_arbiter_if;
  logic        in_cpu_req;
  logic        in_cpu_we;
  logic [14:0] in_cpu_addr;
  logic [11:0] in_cpu_wdata;
  logic        out_cpu_ack;
  logic [11:0] out_cpu_rdata;
  logic        out_mem_en;
  logic        out_mem_we;
  logic [14:0] out_mem_addr;
  logic [11:0] out_mem_wdata;
  logic [11:0] in_mem_rdata;

  modport slave (
    input  in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata, in_mem_rdata,
    output out_cpu_ack, out_cpu_rdata, out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata
  );

  modport master (
    output in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata, in_mem_rdata,
    input  out_cpu_ack, out_cpu_rdata, out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one synchronous-read VRAM between 4x4-replicated 160x120 scan-out and a CPU port.
// Display owns every 4th visible pixel clock; the CPU gets every other slot via req/ack.
module vram_arbiter #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int FB_WIDTH  = 160,
  parameter int FB_WORDS  = 19200
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic [9:0]  in_h_position,
  input  logic [9:0]  in_v_position,
  input  logic        in_horizontal_sync,
  input  logic        in_vertical_sync,
  output logic        out_vga_horizontal_sync,
  output logic        out_vga_vertical_sync,
  output logic [3:0]  out_vga_r,
  output logic [3:0]  out_vga_g,
  output logic [3:0]  out_vga_b,
  vram_arbiter_if.slave bus
);
  localparam logic [9:0]  H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
  localparam logic [14:0] FB_LIM = 15'(FB_WORDS);

  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;

  logic        visible, disp_slot, cpu_issue, cpu_in_range;
  logic [14:0] row_base, disp_addr;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr, addr_q;
  logic [11:0] mem_wdata, wdata_q;
  logic        rd_pend, oor_q;
  logic [11:0] rdata_q, rdata_nxt;
  logic [1:0]  vis_pipe, hs_pipe, vs_pipe;
  logic        slot_d1;
  logic [11:0] pixel_q;

  assign visible   = (in_h_position < H_VIS) && (in_v_position < V_VIS);
  assign disp_slot = visible && (in_h_position[1:0] == 2'b00);

  // (v/4)*160 as (v/4)*128 + (v/4)*32
  assign row_base  = ({7'd0, in_v_position[9:2]} << 7) + ({7'd0, in_v_position[9:2]} << 5);
  assign disp_addr = row_base + {7'd0, in_h_position[9:2]};

  assign cpu_in_range = bus.in_cpu_addr < FB_LIM;
  assign cpu_issue    = (state == IDLE) && bus.in_cpu_req && !disp_slot;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_issue) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes are combinational so an access lands in the cycle it is granted;
  // address/data hold their last value when the RAM is idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rst_n) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (cpu_issue && cpu_in_range) begin
        mem_en    = 1'b1;
        mem_we    = bus.in_cpu_we;
        mem_addr  = bus.in_cpu_addr;
        mem_wdata = bus.in_cpu_wdata;
      end
    end
  end

  assign rdata_nxt = ((state == ACK) && rd_pend) ? (oor_q ? 12'd0 : bus.in_mem_rdata) : rdata_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_pend <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      rd_pend <= cpu_issue && !bus.in_cpu_we;
      oor_q   <= cpu_issue && !cpu_in_range;
      rdata_q <= rdata_nxt;
    end
  end

  assign bus.out_mem_en    = mem_en;
  assign bus.out_mem_we    = mem_we;
  assign bus.out_mem_addr  = mem_addr;
  assign bus.out_mem_wdata = mem_wdata;
  assign bus.out_cpu_ack   = (state == ACK);
  assign bus.out_cpu_rdata = rdata_nxt;

  // Two-stage scan-out: slot -> RAM data -> pixel register, syncs/visible ride alongside.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vis_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      slot_d1  <= 1'b0;
      pixel_q  <= '0;
    end else begin
      vis_pipe <= {vis_pipe[0], visible};
      hs_pipe  <= {hs_pipe[0], in_horizontal_sync};
      vs_pipe  <= {vs_pipe[0], in_vertical_sync};
      slot_d1  <= disp_slot;
      if (slot_d1) pixel_q <= bus.in_mem_rdata;
    end
  end

  assign out_vga_horizontal_sync = hs_pipe[1];
  assign out_vga_vertical_sync   = vs_pipe[1];
  assign out_vga_r = vis_pipe[1] ? pixel_q[11:8] : 4'd0;
  assign out_vga_g = vis_pipe[1] ? pixel_q[7:4]  : 4'd0;
  assign out_vga_b = vis_pipe[1] ? pixel_q[3:0]  : 4'd0;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RAM model returns addr[11:0] for unwritten words.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_vram_arbiter;
  logic       clk_pixel = 1'b0;
  logic       rst_n     = 1'b0;
  logic [9:0] h_pos = '0, v_pos = '0;
  logic       hs_in = 1'b0, vs_in = 1'b0;
  logic       hs_out, vs_out;
  logic [3:0] vr, vg, vb;
  int         vectors = 0, miscompares = 0, acks;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk_pixel               (clk_pixel),
    .rst_n                   (rst_n),
    .in_h_position           (h_pos),
    .in_v_position           (v_pos),
    .in_horizontal_sync      (hs_in),
    .in_vertical_sync        (vs_in),
    .out_vga_horizontal_sync (hs_out),
    .out_vga_vertical_sync   (vs_out),
    .out_vga_r               (vr),
    .out_vga_g               (vg),
    .out_vga_b               (vb),
    .bus                     (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [11:0] wmem [int];
  logic [11:0] ram_q = '0;
  assign bus.in_mem_rdata = ram_q;

  function automatic logic [11:0] ram_rd(input logic [14:0] a);
    return wmem.exists(int'(a)) ? wmem[int'(a)] : a[11:0];
  endfunction

  always @(posedge clk_pixel) begin
    if (bus.out_mem_en) begin
      if (bus.out_mem_we) wmem[int'(bus.out_mem_addr)] = bus.out_mem_wdata;
      else                ram_q <= ram_rd(bus.out_mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic hs, input logic vs,
                     input logic req, input logic we, input logic [14:0] a, input logic [11:0] d);
    @(negedge clk_pixel);
    h_pos = h; v_pos = v; hs_in = hs; vs_in = vs;
    bus.in_cpu_req = req; bus.in_cpu_we = we; bus.in_cpu_addr = a; bus.in_cpu_wdata = d;
    #1;
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, vr, vg, vb};
  endfunction

  initial begin
    bus.in_cpu_req = 1'b0; bus.in_cpu_we = 1'b0; bus.in_cpu_addr = '0; bus.in_cpu_wdata = '0;

    // reset held with a visible slot and a pending write
    cyc(10'd8, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 15'd200, 12'h123);
    cyc(10'd8, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 15'd200, 12'h123);
    chk("rst_mem_en", 32'(bus.out_mem_en), 32'h0);
    chk("rst_mem_addr", 32'(bus.out_mem_addr), 32'h0);
    chk("rst_ack", 32'(bus.out_cpu_ack), 32'h0);
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_hs", 32'(hs_out), 32'h0);
    chk("rst_vs", 32'(vs_out), 32'h0);
    cyc(10'd700, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    rst_n = 1'b1;
    cyc(10'd700, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rel_hs_1", 32'(hs_out), 32'h0);
    cyc(10'd700, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rel_hs_2", 32'(hs_out), 32'h1);

    // scan-out of word 162 at h=8, v=4
    cyc(10'd7, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    cyc(10'd8, 10'd4, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("disp_en", 32'(bus.out_mem_en), 32'h1);
    chk("disp_we", 32'(bus.out_mem_we), 32'h0);
    chk("disp_addr", 32'(bus.out_mem_addr), 32'd162);
    cyc(10'd9, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("idle_en", 32'(bus.out_mem_en), 32'h0);
    chk("idle_addr_hold", 32'(bus.out_mem_addr), 32'd162);
    cyc(10'd10, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rgb_t2", rgb(), 32'd162);
    chk("hs_delay_low", 32'(hs_out), 32'h0);
    cyc(10'd11, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rgb_t3", rgb(), 32'd162);
    chk("hs_delay_high", 32'(hs_out), 32'h1);
    cyc(10'd12, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("disp_addr_163", 32'(bus.out_mem_addr), 32'd163);
    chk("rgb_t4", rgb(), 32'd162);
    cyc(10'd13, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rgb_t5", rgb(), 32'd162);
    cyc(10'd14, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("rgb_t6", rgb(), 32'd163);

    // CPU write colliding with a display slot
    cyc(10'd16, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 15'd100, 12'hABC);
    chk("col_disp_addr", 32'(bus.out_mem_addr), 32'd164);
    chk("col_disp_we", 32'(bus.out_mem_we), 32'h0);
    chk("col_ack_0", 32'(bus.out_cpu_ack), 32'h0);
    cyc(10'd17, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 15'd100, 12'hABC);
    chk("col_cpu_en", 32'(bus.out_mem_en), 32'h1);
    chk("col_cpu_we", 32'(bus.out_mem_we), 32'h1);
    chk("col_cpu_addr", 32'(bus.out_mem_addr), 32'd100);
    chk("col_cpu_wdata", 32'(bus.out_mem_wdata), 32'hABC);
    chk("col_ack_1", 32'(bus.out_cpu_ack), 32'h0);
    cyc(10'd18, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 15'd100, 12'hABC);
    chk("col_ack_2", 32'(bus.out_cpu_ack), 32'h1);
    chk("col_ack_no_access", 32'(bus.out_mem_en), 32'h0);
    cyc(10'd19, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("col_ack_3", 32'(bus.out_cpu_ack), 32'h0);
    chk("col_ram_written", 32'(ram_rd(15'd100)), 32'hABC);

    // blanking read of the last valid word
    cyc(10'd700, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    cyc(10'd700, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    cyc(10'd700, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd19199, 12'h0);
    chk("blk_en", 32'(bus.out_mem_en), 32'h1);
    chk("blk_addr", 32'(bus.out_mem_addr), 32'd19199);
    cyc(10'd701, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd19199, 12'h0);
    chk("blk_ack", 32'(bus.out_cpu_ack), 32'h1);
    chk("blk_rdata", 32'(bus.out_cpu_rdata), 32'hAFF);
    chk("blk_rgb", rgb(), 32'h0);
    cyc(10'd702, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("blk_ack_drop", 32'(bus.out_cpu_ack), 32'h0);
    chk("blk_rdata_hold", 32'(bus.out_cpu_rdata), 32'hAFF);
    cyc(10'd703, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd100, 12'h0);
    cyc(10'd704, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd100, 12'h0);
    chk("rd100_rdata", 32'(bus.out_cpu_rdata), 32'hABC);

    // out-of-range write then read
    cyc(10'd706, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 15'd19200, 12'h555);
    chk("oor_wr_en", 32'(bus.out_mem_en), 32'h0);
    cyc(10'd707, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 15'd19200, 12'h555);
    chk("oor_wr_ack", 32'(bus.out_cpu_ack), 32'h1);
    cyc(10'd708, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd19200, 12'h0);
    chk("oor_rd_en", 32'(bus.out_mem_en), 32'h0);
    cyc(10'd709, 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd19200, 12'h0);
    chk("oor_rd_ack", 32'(bus.out_cpu_ack), 32'h1);
    chk("oor_rd_rdata", 32'(bus.out_cpu_rdata), 32'h0);
    cyc(10'd710, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);

    // back-to-back requests held for 8 cycles
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(10'd720 + 10'(i), 10'd10, 1'b1, 1'b1, 1'b1, 1'b0, 15'd5, 12'h0);
      acks += int'(bus.out_cpu_ack);
    end
    cyc(10'd730, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    acks += int'(bus.out_cpu_ack);
    chk("thru_acks", 32'(acks), 32'd4);
    chk("thru_rdata", 32'(bus.out_cpu_rdata), 32'd5);

    // reset in the middle of an issued write
    cyc(10'd740, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 15'd300, 12'h777);
    chk("mid_issue_en", 32'(bus.out_mem_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(bus.out_mem_en), 32'h0);
    chk("mid_rst_addr", 32'(bus.out_mem_addr), 32'h0);
    chk("mid_rst_rdata", 32'(bus.out_cpu_rdata), 32'h0);
    chk("mid_rst_hs", 32'(hs_out), 32'h0);
    cyc(10'd741, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    rst_n = 1'b1;
    cyc(10'd742, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("mid_no_ack_1", 32'(bus.out_cpu_ack), 32'h0);
    cyc(10'd743, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("mid_no_ack_2", 32'(bus.out_cpu_ack), 32'h0);
    cyc(10'd744, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 15'd300, 12'h777);
    chk("reissue_en", 32'(bus.out_mem_en), 32'h1);
    cyc(10'd745, 10'd10, 1'b1, 1'b1, 1'b1, 1'b1, 15'd300, 12'h777);
    chk("reissue_ack", 32'(bus.out_cpu_ack), 32'h1);
    cyc(10'd746, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0, 12'h0);
    chk("reissue_ram", 32'(ram_rd(15'd300)), 32'h777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
